// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC, imem req/ack, valid/ready to control unit
// Optional halt-on-zero-instruction behaviour is enabled by defining IFU_HALT_ON_ZERO_EN.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    input  logic              jump,
    input  logic [15:0]       jump_offset,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC0 = {RESET_PC[ADDR_W-1:2], 2'b00};

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
`ifdef IFU_HALT_ON_ZERO_EN
        , HALT
`endif
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_d;
    logic              req_d, valid_d, halted_d;
    logic [ADDR_W-1:0] addr_d, pc_d;
    logic [31:0]       instr_d;
    logic [ADDR_W-1:0] offset_ext;
    logic [ADDR_W-1:0] next_pc;

    // Word offset sign-extended then scaled to bytes; sums wrap modulo 2^ADDR_W.
    assign offset_ext = {{(ADDR_W-16){jump_offset[15]}}, jump_offset};
    assign next_pc    = jump ? pc + ADDR_W'(4) + (offset_ext << 2) : pc + ADDR_W'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= PC0;
            imem_req    <= 1'b0;
            imem_addr   <= PC0;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            pc          <= PC0;
            halted      <= 1'b0;
        end else begin
            state       <= state_d;
            fetch_pc    <= fetch_pc_d;
            imem_req    <= req_d;
            imem_addr   <= addr_d;
            instr       <= instr_d;
            instr_valid <= valid_d;
            pc          <= pc_d;
            halted      <= halted_d;
        end
    end

    always_comb begin
        state_d    = state;
        fetch_pc_d = fetch_pc;
        req_d      = imem_req;
        addr_d     = imem_addr;
        instr_d    = instr;
        valid_d    = instr_valid;
        pc_d       = pc;
        halted_d   = halted;
        case (state)
            IDLE: begin
                if (fetch_en) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc;
                end
            end
            // fetch_en is deliberately ignored here: an issued request always completes.
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    pc_d    = fetch_pc;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
`ifdef IFU_HALT_ON_ZERO_EN
                    if (instr == 32'h0) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else
`endif
                    begin
                        fetch_pc_d = next_pc;
                        addr_d     = next_pc;
                        if (fetch_en) begin
                            state_d = REQ;
                            req_d   = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = state;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam logic [31:0] K = 32'hA5A50000;

    logic        clk = 1'b0;
    logic        rst_n, fetch_en, imem_ack, instr_ready, jump;
    logic [31:0] imem_rdata;
    logic [15:0] jump_offset;
    logic        imem_req, instr_valid, halted;
    logic [31:0] imem_addr, instr, pc;

    logic        b_one = 1'b1;
    logic        b_zero = 1'b0;
    logic [15:0] b_off = 16'h0;
    logic        b_req, b_valid, b_halted, b_ack;
    logic [31:0] b_addr, b_instr, b_pc, b_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
        .jump(jump), .jump_offset(jump_offset), .halted(halted)
    );

    // Second instance: zero-wait memory, always ready, reset address near the top of memory.
    assign b_ack   = b_req;
    assign b_rdata = b_addr ^ K;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFFFFFF)) u_wrap (
        .clk(clk), .rst_n(rst_n), .fetch_en(b_one),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ack(b_ack), .imem_rdata(b_rdata),
        .instr(b_instr), .instr_valid(b_valid), .instr_ready(b_one), .pc(b_pc),
        .jump(b_zero), .jump_offset(b_off), .halted(b_halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete fetch: wait for the request, ack after ack_dly cycles, hold ready low
    // for rdy_dly cycles, then consume with the given jump decision.
    task automatic do_fetch(input int ack_dly, input int rdy_dly, input bit j,
                            input logic [15:0] off, input int drop_at, input bit zero);
        logic [31:0] word, tgt;
        int          n, so;
        n = 0;
        while (imem_req !== 1'b1 && n < 4) begin
            step();
            n++;
        end
        chk("req_rise", {31'b0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, exp_addr);
        for (int i = 0; i < ack_dly; i++) begin
            if (i == drop_at) fetch_en = 1'b0;
            imem_ack = 1'b0;
            step();
            chk("req_hold", {31'b0, imem_req}, 32'd1);
            chk("addr_hold", imem_addr, exp_addr);
            chk("no_valid_in_req", {31'b0, instr_valid}, 32'd0);
        end
        word       = zero ? 32'h0 : (exp_addr ^ K);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("valid", {31'b0, instr_valid}, 32'd1);
        chk("instr", instr, word);
        chk("pc", pc, exp_addr);
        chk("req_drop", {31'b0, imem_req}, 32'd0);
        for (int i = 0; i < rdy_dly; i++) begin
            instr_ready = 1'b0;
            imem_ack    = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            jump        = 1'($urandom_range(0, 1));
            jump_offset = 16'($urandom);
            step();
            chk("hold_valid", {31'b0, instr_valid}, 32'd1);
            chk("hold_instr", instr, word);
            chk("hold_pc", pc, exp_addr);
            chk("hold_no_req", {31'b0, imem_req}, 32'd0);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        jump        = j;
        jump_offset = off;
        step();
        instr_ready = 1'b0;
        jump        = 1'($urandom_range(0, 1));
        jump_offset = 16'($urandom);
        chk("valid_clr", {31'b0, instr_valid}, 32'd0);
        so  = $signed(off);
        tgt = exp_addr + 32'd4 + (j ? 32'(so * 4) : 32'd0);
`ifdef IFU_HALT_ON_ZERO_EN
        if (zero) begin
            chk("halted_set", {31'b0, halted}, 32'd1);
            chk("halt_no_req", {31'b0, imem_req}, 32'd0);
            repeat (3) begin
                step();
                chk("halt_stays", {31'b0, halted}, 32'd1);
                chk("halt_req_low", {31'b0, imem_req}, 32'd0);
                chk("halt_valid_low", {31'b0, instr_valid}, 32'd0);
            end
            return;
        end
`endif
        exp_addr = tgt;
        chk("not_halted", {31'b0, halted}, 32'd0);
        if (fetch_en) begin
            chk("next_req", {31'b0, imem_req}, 32'd1);
            chk("next_addr", imem_addr, tgt);
        end else begin
            chk("idle_req", {31'b0, imem_req}, 32'd0);
            step();
            chk("idle_stays", {31'b0, imem_req}, 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; fetch_en = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        jump = 1'b0; jump_offset = 16'h0; imem_rdata = 32'h0;
        step();
        step();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_wrap_addr", b_addr, 32'hFFFFFFFC);
        chk("rst_wrap_pc", b_pc, 32'hFFFFFFFC);

        rst_n    = 1'b1;
        imem_ack = 1'b1;
        step();
        chk("idle_no_fetch", {31'b0, imem_req}, 32'd0);
        chk("wrap_req1", b_addr, 32'hFFFFFFFC);
        chk("wrap_req1_up", {31'b0, b_req}, 32'd1);
        step();
        chk("idle_ack_ignored", {31'b0, instr_valid}, 32'd0);
        chk("wrap_instr", b_instr, 32'hFFFFFFFC ^ K);
        chk("wrap_pc", b_pc, 32'hFFFFFFFC);
        step();
        chk("wrap_req2", b_addr, 32'h0);
        chk("wrap_req2_up", {31'b0, b_req}, 32'd1);
        imem_ack = 1'b0;

        exp_addr = 32'h0;
        fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) do_fetch(0, 0, 1'b0, 16'h0, -1, 1'b0);
        chk("seq_reach_10", exp_addr, 32'h10);
        do_fetch(0, 5, 1'b1, 16'h0003, -1, 1'b0);
        chk("jump_fwd_addr", imem_addr, 32'h20);
        do_fetch(1, 0, 1'b1, 16'hFFFE, -1, 1'b0);
        chk("jump_back_addr", imem_addr, 32'h1C);
        do_fetch(3, 0, 1'b0, 16'h0, 1, 1'b0);
        fetch_en = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                     16'($urandom_range(0, 64)) - 16'd32, -1, 1'b0);
        end

        chk("pre_reset_req", {31'b0, imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_req", {31'b0, imem_req}, 32'd0);
        chk("async_valid", {31'b0, instr_valid}, 32'd0);
        chk("async_addr", imem_addr, 32'h0);
        chk("async_pc", pc, 32'h0);
        step();
        rst_n    = 1'b1;
        exp_addr = 32'h0;

        do_fetch(0, 0, 1'b0, 16'h0, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
